// File: rtl/mem_tx_scheduler_if.sv
// Bundle of request, payload, TX and RX-routing signals between the two
// requesters (prefetcher, execution unit) and the TX link scheduler.
interface mem_tx_scheduler_if #(
    parameter int IO_BITS        = 2,
    parameter int CMD_BITS       = 4,
    parameter int PAYLOAD_CYCLES = 8
);
    localparam int CW = $clog2(PAYLOAD_CYCLES) + 1;

    logic                pf_cmd_valid;
    logic [CMD_BITS-1:0] pf_cmd;
    logic                pf_cmd_started;
    logic [IO_BITS-1:0]  pf_data;
    logic                pf_data_next;

    logic                ex_cmd_valid;
    logic [CMD_BITS-1:0] ex_cmd;
    logic                ex_has_resp;
    logic                ex_cmd_started;
    logic [IO_BITS-1:0]  ex_data;
    logic                ex_data_next;

    logic [IO_BITS-1:0]  tx_pins;
    logic                tx_active;
    logic [CW-1:0]       tx_counter;
    logic                tx_done;

    logic                rx_data_valid;
    logic                rx_done;
    logic                pf_rx_data_valid;
    logic                pf_rx_done;
    logic                ex_rx_data_valid;
    logic                ex_rx_done;
    logic                resp_err;

    // Scheduler side
    modport slave (
        input  pf_cmd_valid, pf_cmd, pf_data,
        input  ex_cmd_valid, ex_cmd, ex_has_resp, ex_data,
        input  rx_data_valid, rx_done,
        output pf_cmd_started, pf_data_next, ex_cmd_started, ex_data_next,
        output tx_pins, tx_active, tx_counter, tx_done,
        output pf_rx_data_valid, pf_rx_done, ex_rx_data_valid, ex_rx_done,
        output resp_err
    );

    // Requester / link side
    modport master (
        output pf_cmd_valid, pf_cmd, pf_data,
        output ex_cmd_valid, ex_cmd, ex_has_resp, ex_data,
        output rx_data_valid, rx_done,
        input  pf_cmd_started, pf_data_next, ex_cmd_started, ex_data_next,
        input  tx_pins, tx_active, tx_counter, tx_done,
        input  pf_rx_data_valid, pf_rx_done, ex_rx_data_valid, ex_rx_done,
        input  resp_err
    );
endinterface

// File: rtl/mem_tx_scheduler.sv
// Shares one serial TX link between the prefetcher (pf) and the execution
// unit (ex): arbitrates, serialises header then payload, and keeps an
// in-order tag FIFO so RX responses are steered back to their requester.
module mem_tx_scheduler #(
    parameter int IO_BITS         = 2,
    parameter int PAYLOAD_CYCLES  = 8,
    parameter int CMD_BITS        = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic             clk,
    input logic             reset,
    mem_tx_scheduler_if.slave bus
);
    localparam int HDR_CYCLES = CMD_BITS / IO_BITS;
    localparam int CW = $clog2(PAYLOAD_CYCLES) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int NW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] HDR_LAST = CW'(HDR_CYCLES - 1);
    localparam logic [CW-1:0] PAY_LAST = CW'(PAYLOAD_CYCLES - 1);
    localparam logic [NW-1:0] TAG_MAX  = NW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic [CMD_BITS-1:0] cmd_q;
    logic                src_ex_q;
    logic                last_ex;
    logic                resp_err_q;

    // Tag FIFO: one bit per outstanding read, 1 = response belongs to ex
    logic                tag_mem [MAX_OUTSTANDING];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [NW-1:0]       tag_count;

    logic tag_full, tag_empty, head_ex;
    logic pf_ok, ex_ok, window, grant, grant_ex, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Fullness is judged on the registered count, so a same-cycle pop
    // never makes room for the grant.
    assign tag_full  = (tag_count == TAG_MAX);
    assign tag_empty = (tag_count == '0);
    assign head_ex   = tag_mem[rd_ptr];

    assign pf_ok    = bus.pf_cmd_valid && !tag_full;
    assign ex_ok    = bus.ex_cmd_valid && (!bus.ex_has_resp || !tag_full);
    assign window   = (state == IDLE) || ((state == PAYLOAD) && (cnt == PAY_LAST));
    assign grant    = window && (pf_ok || ex_ok);
    assign grant_ex = ex_ok && !(last_ex && pf_ok);
    assign push     = grant && (!grant_ex || bus.ex_has_resp);
    assign pop      = bus.rx_done && !tag_empty;

    // State and beat counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic and link/requester outputs
    always_comb begin
        state_next              = state;
        cnt_next                = cnt;
        bus.tx_pins             = '0;
        bus.tx_done             = 1'b0;
        bus.pf_data_next        = 1'b0;
        bus.ex_data_next        = 1'b0;
        bus.tx_active           = (state != IDLE);
        bus.tx_counter          = cnt;
        bus.pf_cmd_started      = grant && !grant_ex;
        bus.ex_cmd_started      = grant && grant_ex;
        bus.pf_rx_data_valid    = bus.rx_data_valid && !tag_empty && !head_ex;
        bus.ex_rx_data_valid    = bus.rx_data_valid && !tag_empty && head_ex;
        bus.pf_rx_done          = bus.rx_done && !tag_empty && !head_ex;
        bus.ex_rx_done          = bus.rx_done && !tag_empty && head_ex;
        bus.resp_err            = resp_err_q;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = HEADER;
                    cnt_next   = '0;
                end
            end
            HEADER: begin
                for (int unsigned k = 0; k < HDR_CYCLES; k++) begin
                    if (cnt == CW'(k)) bus.tx_pins = cmd_q[k*IO_BITS +: IO_BITS];
                end
                if (cnt == HDR_LAST) begin
                    state_next = PAYLOAD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PAYLOAD: begin
                bus.tx_pins      = src_ex_q ? bus.ex_data : bus.pf_data;
                bus.ex_data_next = src_ex_q;
                bus.pf_data_next = !src_ex_q;
                if (cnt == PAY_LAST) begin
                    bus.tx_done = 1'b1;
                    state_next  = grant ? HEADER : IDLE;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Reset aborts at once: no strobes leak out during the reset cycle.
        if (reset) begin
            bus.tx_pins          = '0;
            bus.tx_done          = 1'b0;
            bus.pf_data_next     = 1'b0;
            bus.ex_data_next     = 1'b0;
            bus.tx_active        = 1'b0;
            bus.tx_counter       = '0;
            bus.pf_cmd_started   = 1'b0;
            bus.ex_cmd_started   = 1'b0;
            bus.pf_rx_data_valid = 1'b0;
            bus.ex_rx_data_valid = 1'b0;
            bus.pf_rx_done       = 1'b0;
            bus.ex_rx_done       = 1'b0;
            bus.resp_err         = 1'b0;
        end
    end

    // Latch the granted command, its source and the fairness bit
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q    <= '0;
            src_ex_q <= 1'b0;
            last_ex  <= 1'b0;
        end else if (grant) begin
            cmd_q    <= grant_ex ? bus.ex_cmd : bus.pf_cmd;
            src_ex_q <= grant_ex;
            last_ex  <= grant_ex;
        end
    end

    // Tag FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            tag_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: tag_count <= tag_count;
            endcase
        end
    end

    // Tag storage (contents are don't-care until pushed)
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant_ex;
    end

    // Sticky error for RX activity with no outstanding read
    always_ff @(posedge clk) begin
        if (reset) resp_err_q <= 1'b0;
        else if ((bus.rx_done || bus.rx_data_valid) && tag_empty) resp_err_q <= 1'b1;
    end
endmodule

// File: tb/tb_mem_tx_scheduler.sv
// Directed bench for mem_tx_scheduler: grant, header/payload sequencing,
// arbitration, tag FIFO limits, RX routing and mid-transaction reset.
module tb_mem_tx_scheduler;
    localparam logic [1:0] PF_DATA = 2'b11;
    localparam logic [1:0] EX_DATA = 2'b10;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_tx_scheduler_if #(.IO_BITS(2), .CMD_BITS(4), .PAYLOAD_CYCLES(8)) bus ();

    mem_tx_scheduler #(
        .IO_BITS(2), .PAYLOAD_CYCLES(8), .CMD_BITS(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_cycle(input string tag, input logic exp_pf, input logic exp_ex);
        @(negedge clk);
        check({tag, ".pf_started"}, 32'(bus.pf_cmd_started), 32'(exp_pf));
        check({tag, ".ex_started"}, 32'(bus.ex_cmd_started), 32'(exp_ex));
        step();
    endtask

    // Checks the full header+payload of one transaction, starting on header beat 0
    task automatic expect_txn(input string tag, input logic ex, input logic [3:0] cmd,
                              input logic next_pf, input logic next_ex);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check({tag, ".hdr_active"},  32'(bus.tx_active), 32'd1);
            check({tag, ".hdr_pins"},    32'(bus.tx_pins), 32'(cmd[2*k +: 2]));
            check({tag, ".hdr_counter"}, 32'(bus.tx_counter), 32'(k));
            check({tag, ".hdr_next"},    32'({bus.pf_data_next, bus.ex_data_next}), 32'd0);
            check({tag, ".hdr_done"},    32'(bus.tx_done), 32'd0);
            check({tag, ".hdr_started"}, 32'({bus.pf_cmd_started, bus.ex_cmd_started}), 32'd0);
            step();
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check({tag, ".pay_active"},  32'(bus.tx_active), 32'd1);
            check({tag, ".pay_pins"},    32'(bus.tx_pins), 32'(ex ? EX_DATA : PF_DATA));
            check({tag, ".pay_counter"}, 32'(bus.tx_counter), 32'(k));
            check({tag, ".pay_pf_next"}, 32'(bus.pf_data_next), 32'(!ex));
            check({tag, ".pay_ex_next"}, 32'(bus.ex_data_next), 32'(ex));
            check({tag, ".pay_done"},    32'(bus.tx_done), 32'(k == 7));
            check({tag, ".pay_pf_started"}, 32'(bus.pf_cmd_started), 32'((k == 7) && next_pf));
            check({tag, ".pay_ex_started"}, 32'(bus.ex_cmd_started), 32'((k == 7) && next_ex));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.pf_cmd_valid = 1'b0; bus.pf_cmd = '0; bus.pf_data = PF_DATA;
        bus.ex_cmd_valid = 1'b0; bus.ex_cmd = '0; bus.ex_has_resp = 1'b0; bus.ex_data = EX_DATA;
        bus.rx_data_valid = 1'b0; bus.rx_done = 1'b0;
        repeat (2) step();

        // Reset state
        @(negedge clk);
        check("rst.active",  32'(bus.tx_active), 32'd0);
        check("rst.pins",    32'(bus.tx_pins), 32'd0);
        check("rst.counter", 32'(bus.tx_counter), 32'd0);
        check("rst.err",     32'(bus.resp_err), 32'd0);
        check("rst.done",    32'(bus.tx_done), 32'd0);
        step();

        // 1: pf read granted on the first cycle out of reset
        reset = 1'b0;
        bus.pf_cmd_valid = 1'b1; bus.pf_cmd = 4'b1001;
        grant_cycle("s1", 1'b1, 1'b0);
        bus.pf_cmd_valid = 1'b0;
        expect_txn("s1", 1'b0, 4'b1001, 1'b0, 1'b0);
        @(negedge clk);
        check("s1.idle_active", 32'(bus.tx_active), 32'd0);
        check("s1.idle_pins",   32'(bus.tx_pins), 32'd0);
        step();

        // ex read: FIFO becomes [pf, ex] (full)
        bus.ex_cmd_valid = 1'b1; bus.ex_has_resp = 1'b1; bus.ex_cmd = 4'b0110;
        grant_cycle("s4a", 1'b0, 1'b1);
        bus.ex_cmd_valid = 1'b0; bus.ex_has_resp = 1'b0;
        expect_txn("s4a", 1'b1, 4'b0110, 1'b0, 1'b0);

        // 3: FIFO full stalls pf; ex without response still granted
        bus.pf_cmd_valid = 1'b1; bus.pf_cmd = 4'b0011;
        repeat (3) begin
            @(negedge clk);
            check("s3.pf_stall",  32'(bus.pf_cmd_started), 32'd0);
            check("s3.idle",      32'(bus.tx_active), 32'd0);
            step();
        end
        bus.ex_cmd_valid = 1'b1; bus.ex_has_resp = 1'b0; bus.ex_cmd = 4'b1100;
        grant_cycle("s3", 1'b0, 1'b1);
        bus.ex_cmd_valid = 1'b0;
        expect_txn("s3", 1'b1, 4'b1100, 1'b0, 1'b0);

        // 4: first response goes to pf; pop does not free space the same cycle
        bus.rx_data_valid = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("s4.pf_rx_dv", 32'(bus.pf_rx_data_valid), 32'd1);
            check("s4.ex_rx_dv", 32'(bus.ex_rx_data_valid), 32'd0);
            check("s4.pf_stall", 32'(bus.pf_cmd_started), 32'd0);
            step();
        end
        bus.rx_data_valid = 1'b0; bus.rx_done = 1'b1;
        @(negedge clk);
        check("s4.pf_rx_done",  32'(bus.pf_rx_done), 32'd1);
        check("s4.ex_rx_done",  32'(bus.ex_rx_done), 32'd0);
        check("s4.pop_no_room", 32'(bus.pf_cmd_started), 32'd0);
        step();
        bus.rx_done = 1'b0;
        grant_cycle("s4.pf_after_pop", 1'b1, 1'b0);
        bus.pf_cmd_valid = 1'b0;
        expect_txn("s4.pf", 1'b0, 4'b0011, 1'b0, 1'b0);

        // FIFO [ex, pf]: next response belongs to ex
        bus.rx_data_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("s4.ex_rx_dv2", 32'(bus.ex_rx_data_valid), 32'd1);
            check("s4.pf_rx_dv2", 32'(bus.pf_rx_data_valid), 32'd0);
            step();
        end
        bus.rx_data_valid = 1'b0; bus.rx_done = 1'b1;
        @(negedge clk);
        check("s4.ex_rx_done2", 32'(bus.ex_rx_done), 32'd1);
        check("s4.pf_rx_done2", 32'(bus.pf_rx_done), 32'd0);
        step();

        // Push and pop together: pop pf, push ex, count unchanged
        bus.rx_done = 1'b1;
        bus.ex_cmd_valid = 1'b1; bus.ex_has_resp = 1'b1; bus.ex_cmd = 4'b0101;
        @(negedge clk);
        check("pp.pf_rx_done", 32'(bus.pf_rx_done), 32'd1);
        check("pp.ex_rx_done", 32'(bus.ex_rx_done), 32'd0);
        check("pp.ex_started", 32'(bus.ex_cmd_started), 32'd1);
        step();
        bus.rx_done = 1'b0; bus.ex_cmd_valid = 1'b0; bus.ex_has_resp = 1'b0;
        expect_txn("pp", 1'b1, 4'b0101, 1'b0, 1'b0);
        bus.rx_done = 1'b1;
        @(negedge clk);
        check("pp.ex_rx_done3", 32'(bus.ex_rx_done), 32'd1);
        check("pp.pf_rx_done3", 32'(bus.pf_rx_done), 32'd0);
        step();

        // 5: RX with empty FIFO -> sticky error, nothing routed
        bus.rx_done = 1'b1; bus.rx_data_valid = 1'b1;
        @(negedge clk);
        check("s5.pf_rx_done", 32'(bus.pf_rx_done), 32'd0);
        check("s5.ex_rx_done", 32'(bus.ex_rx_done), 32'd0);
        check("s5.pf_rx_dv",   32'(bus.pf_rx_data_valid), 32'd0);
        check("s5.ex_rx_dv",   32'(bus.ex_rx_data_valid), 32'd0);
        check("s5.err_before", 32'(bus.resp_err), 32'd0);
        step();
        bus.rx_done = 1'b0; bus.rx_data_valid = 1'b0;
        @(negedge clk);
        check("s5.err_set", 32'(bus.resp_err), 32'd1);
        step();
        bus.pf_cmd_valid = 1'b1; bus.pf_cmd = 4'b1010;
        grant_cycle("s5", 1'b1, 1'b0);
        bus.pf_cmd_valid = 1'b0;
        expect_txn("s5", 1'b0, 4'b1010, 1'b0, 1'b0);
        @(negedge clk);
        check("s5.err_sticky", 32'(bus.resp_err), 32'd1);
        step();

        // 2: both valid, last_ex=0 -> ex first; then alternate back-to-back
        bus.pf_cmd_valid = 1'b1; bus.pf_cmd = 4'b0111;
        bus.ex_cmd_valid = 1'b1; bus.ex_has_resp = 1'b0; bus.ex_cmd = 4'b1110;
        grant_cycle("s2", 1'b0, 1'b1);
        expect_txn("s2.ex", 1'b1, 4'b1110, 1'b1, 1'b0);
        bus.pf_cmd_valid = 1'b0;
        expect_txn("s2.pf", 1'b0, 4'b0111, 1'b0, 1'b1);
        bus.ex_cmd_valid = 1'b0;
        expect_txn("s2.ex2", 1'b1, 4'b1110, 1'b0, 1'b0);

        // 6: reset on payload beat 3 (FIFO currently full with [pf, pf])
        bus.ex_cmd_valid = 1'b1; bus.ex_has_resp = 1'b0; bus.ex_cmd = 4'b0001;
        grant_cycle("s6", 1'b0, 1'b1);
        bus.ex_cmd_valid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check("s6.beat3_counter", 32'(bus.tx_counter), 32'd3);
        check("s6.beat3_next",    32'(bus.ex_data_next), 32'd1);
        reset = 1'b1;
        step();
        @(negedge clk);
        check("s6.rst_active", 32'(bus.tx_active), 32'd0);
        check("s6.rst_done",   32'(bus.tx_done), 32'd0);
        check("s6.rst_next",   32'(bus.ex_data_next), 32'd0);
        step();
        reset = 1'b0;
        bus.rx_done = 1'b1;
        bus.pf_cmd_valid = 1'b1; bus.pf_cmd = 4'b1111;
        @(negedge clk);
        check("s6.post_active",  32'(bus.tx_active), 32'd0);
        check("s6.post_pins",    32'(bus.tx_pins), 32'd0);
        check("s6.post_counter", 32'(bus.tx_counter), 32'd0);
        check("s6.post_done",    32'(bus.tx_done), 32'd0);
        check("s6.post_err",     32'(bus.resp_err), 32'd0);
        check("s6.empty_pf_rx",  32'(bus.pf_rx_done), 32'd0);
        check("s6.empty_ex_rx",  32'(bus.ex_rx_done), 32'd0);
        check("s6.pf_granted",   32'(bus.pf_cmd_started), 32'd1);
        step();
        bus.rx_done = 1'b0; bus.pf_cmd_valid = 1'b0;
        @(negedge clk);
        check("s6.empty_err", 32'(bus.resp_err), 32'd1);
        check("s6.hdr_active", 32'(bus.tx_active), 32'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
